// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the uart_tx byte-source arbiter: parameter defaults,
// FSM state encoding and the frame-length helper.
package uart_tx_arbiter_pkg;

   localparam int DEF_N_REQ        = 4;
   localparam int DEF_BAUD_CNT_MAX = 5207;
   localparam int DEF_FRAME_BITS   = 10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2
   } arb_state_t;

   // Clocks needed for uart_tx to shift one complete frame out.
   function automatic int frame_cycles(input int baud_cnt_max, input int frame_bits);
      return (baud_cnt_max + 1) * frame_bits;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or above the
// pointer, otherwise the lowest eligible one (wrap-around search).
module uart_tx_arbiter_rr_pick #(
   parameter int N = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [N-1:0]  i_mask,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   logic [N-1:0]  w_elig;
   logic [N-1:0]  w_hi_mask;
   logic [N-1:0]  w_req_hi;
   logic [N-1:0]  w_sel;
   logic [IW-1:0] w_idx_or [N+1];

   assign w_elig = i_req & i_mask;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_pos
         assign w_hi_mask[gi]   = (IW'(gi) >= i_ptr);
         assign w_idx_or[gi+1]  = w_idx_or[gi] | (o_grant[gi] ? IW'(gi) : '0);
      end
   endgenerate

   assign w_idx_or[0] = '0;

   // Searching the upper slice first and falling back to the full vector
   // gives ptr, ptr+1, .., N-1, 0, .., ptr-1 ordering.
   assign w_req_hi = w_elig & w_hi_mask;
   assign w_sel    = (|w_req_hi) ? w_req_hi : w_elig;
   assign o_grant  = w_sel & (~w_sel + N'(1));
   assign o_idx    = w_idx_or[N];
   assign o_any    = |w_elig;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_REQ byte sources: round-robin accept, one-cycle
// launch pulse, then a frame-length wait since uart_tx has no ready signal.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_REQ        = DEF_N_REQ,
   parameter int BAUD_CNT_MAX = DEF_BAUD_CNT_MAX,
   parameter int FRAME_BITS   = DEF_FRAME_BITS,
   localparam int FRAME_CYCLES = frame_cycles(BAUD_CNT_MAX, FRAME_BITS),
   localparam int IW           = $clog2(N_REQ),
   localparam int CW           = $clog2(FRAME_CYCLES)
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_ready,
   output logic [7:0]           pi_data,
   output logic                 pi_data_flag,
   output logic                 tx_busy,
   output logic [IW-1:0]        grant_id
);

   arb_state_t    r_state;
   arb_state_t    w_state_next;
   logic [IW-1:0] r_rr_ptr;
   logic [IW-1:0] r_lock_id;
   logic [IW-1:0] r_grant;
   logic          r_locked;
   logic [CW-1:0] r_count;
   logic [7:0]    r_data;

   logic [N_REQ-1:0] w_mask;
   logic [N_REQ-1:0] w_grant;
   logic [IW-1:0]    w_idx;
   logic             w_any;
   logic             w_accept;
   logic             w_last;
   logic [7:0]       w_byte_or [N_REQ+1];

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_req
         // While locked only the lock owner may be picked.
         assign w_mask[gi]      = ~r_locked | (r_lock_id == IW'(gi));
         assign w_byte_or[gi+1] = w_byte_or[gi] | (req_data[8*gi +: 8] & {8{w_grant[gi]}});
      end
   endgenerate

   assign w_byte_or[0] = '0;
   assign w_last       = |(req_last & w_grant);

   uart_tx_arbiter_rr_pick #(
      .N (N_REQ)
   ) u_rr_pick (
      .i_req   (req_valid),
      .i_mask  (w_mask),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // Reset also masks the combinational accept so req_ready reads 0 while held.
   assign w_accept = (r_state == ST_IDLE) & w_any & ~sys_rst;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_accept) w_state_next = ST_LAUNCH;
         ST_LAUNCH: w_state_next = ST_WAIT;
         ST_WAIT:   if (r_count == '0) w_state_next = ST_IDLE;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready    = '0;
      pi_data_flag = 1'b0;
      tx_busy      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) req_ready = w_grant;
         end
         ST_LAUNCH: begin
            pi_data_flag = 1'b1;
            tx_busy      = 1'b1;
         end
         ST_WAIT: begin
            tx_busy = 1'b1;
         end
         default: begin
            tx_busy = 1'b0;
         end
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_data    <= '0;
         r_grant   <= '0;
         r_locked  <= 1'b0;
         r_lock_id <= '0;
         r_rr_ptr  <= '0;
         r_count   <= '0;
      end else begin
         if (w_accept) begin
            r_data  <= w_byte_or[N_REQ];
            r_grant <= w_idx;
            if (w_last) begin
               r_locked <= 1'b0;
               r_rr_ptr <= (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + IW'(1);
            end else begin
               r_locked  <= 1'b1;
               r_lock_id <= w_idx;
            end
         end
         // Loaded in LAUNCH so WAIT sees FRAME_CYCLES-1 down to 0 inclusive.
         if (r_state == ST_LAUNCH) begin
            r_count <= CW'(FRAME_CYCLES - 1);
         end else if ((r_state == ST_WAIT) && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   assign pi_data  = r_data;
   assign grant_id = r_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with BAUD_CNT_MAX=3 (40-clock frames,
// launches spaced 42 clocks).
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data  = '0;
   logic [3:0]  req_last  = '0;
   logic [3:0]  req_ready;
   logic [7:0]  pi_data;
   logic        pi_data_flag;
   logic        tx_busy;
   logic [1:0]  grant_id;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   logic [8:0] sq_mem  [4][8];
   int         sq_head [4];
   int         sq_len  [4];

   logic [3:0] acc_rdy  [$];
   int         acc_t    [$];
   logic [7:0] launch_d [$];
   int         launch_t [$];

   uart_tx_arbiter #(
      .N_REQ        (4),
      .BAUD_CNT_MAX (3),
      .FRAME_BITS   (10)
   ) dut (
      .sys_clk      (clk),
      .sys_rst      (rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .pi_data      (pi_data),
      .pi_data_flag (pi_data_flag),
      .tx_busy      (tx_busy),
      .grant_id     (grant_id)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (pi_data_flag === 1'b1) begin
         launch_d.push_back(pi_data);
         launch_t.push_back(cyc);
      end
   end

   task automatic clear_queues();
      for (int i = 0; i < 4; i++) begin
         sq_head[i] = 0;
         sq_len[i]  = 0;
      end
   endtask

   task automatic push(input int i, input logic [7:0] d, input logic last);
      sq_mem[i][sq_len[i]] = {last, d};
      sq_len[i] = sq_len[i] + 1;
   endtask

   task automatic drive_from_queues();
      for (int i = 0; i < 4; i++) begin
         if (sq_head[i] < sq_len[i]) begin
            req_valid[i]        = 1'b1;
            req_data[8*i +: 8]  = sq_mem[i][sq_head[i]][7:0];
            req_last[i]         = sq_mem[i][sq_head[i]][8];
         end else begin
            req_valid[i]        = 1'b0;
            req_data[8*i +: 8]  = 8'h00;
            req_last[i]         = 1'b0;
         end
      end
   endtask

   // Presents queued bytes and records each accept (ready vector and cycle).
   task automatic run_queues(input int n_exp, output bit ok);
      bit got;
      int id;
      ok = 1'b1;
      acc_rdy.delete();
      acc_t.delete();
      for (int k = 0; k < n_exp && ok; k++) begin
         drive_from_queues();
         got = 1'b0;
         id  = 0;
         for (int w = 0; w < 100 && !got; w++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) begin
               got = 1'b1;
               acc_rdy.push_back(req_ready);
               acc_t.push_back(cyc);
               for (int i = 0; i < 4; i++) if (req_ready[i]) id = i;
            end
         end
         if (!got) begin
            ok = 1'b0;
         end else begin
            @(posedge clk);
            #1;
            sq_head[id] = sq_head[id] + 1;
         end
      end
      if (!ok) clear_queues();
      drive_from_queues();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_queues();
      drive_from_queues();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      vectors++;
      if ({req_ready, pi_data, pi_data_flag, tx_busy, grant_id} !== 16'h0000) begin
         $display("FAIL reset_outputs: got %h, expected 0000",
                  {req_ready, pi_data, pi_data_flag, tx_busy, grant_id});
         miscompares++;
      end
      req_valid = 4'b0001;
      #1;
      vectors++;
      if (req_ready !== 4'b0000) begin
         $display("FAIL reset_ready_held: got %b, expected 0000", req_ready);
         miscompares++;
      end
      req_valid = 4'b0000;
      do_reset();
      $display("reset: outputs checked");
   endtask

   task automatic test_single();
      bit ok;
      int n;
      launch_d.delete();
      launch_t.delete();
      push(2, 8'hA5, 1'b1);
      run_queues(1, ok);
      vectors++;
      if (!ok) begin
         $display("FAIL single_accept: timeout, got no ready, expected 0100");
         miscompares++;
         return;
      end
      vectors++;
      if (acc_rdy[0] !== 4'b0100) begin
         $display("FAIL single_ready: got %b, expected 0100", acc_rdy[0]);
         miscompares++;
      end
      @(negedge clk);
      #1;
      vectors++;
      if (pi_data_flag !== 1'b1 || pi_data !== 8'hA5) begin
         $display("FAIL single_launch: got flag=%b data=%h, expected flag=1 data=a5",
                  pi_data_flag, pi_data);
         miscompares++;
      end
      vectors++;
      if (cyc !== acc_t[0] + 1) begin
         $display("FAIL single_latency: got launch cycle %0d, expected %0d", cyc, acc_t[0] + 1);
         miscompares++;
      end
      vectors++;
      if (grant_id !== 2'd2) begin
         $display("FAIL single_grant_id: got %0d, expected 2", grant_id);
         miscompares++;
      end
      n = (tx_busy === 1'b1) ? 1 : 0;
      for (int w = 0; w < 100 && tx_busy === 1'b1; w++) begin
         @(negedge clk);
         if (tx_busy === 1'b1) n++;
      end
      vectors++;
      if (n !== 41) begin
         $display("FAIL single_busy_len: got %0d cycles, expected 41", n);
         miscompares++;
      end
      vectors++;
      if (launch_d.size() !== 1) begin
         $display("FAIL single_flag_count: got %0d pulses, expected 1", launch_d.size());
         miscompares++;
      end
      $display("single: req2 byte a5 accepted at cycle %0d, busy %0d cycles", acc_t[0], n);
   endtask

   task automatic test_contention();
      bit ok;
      logic [3:0] exp_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [7:0] exp_d   [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
      do_reset();
      launch_d.delete();
      launch_t.delete();
      push(0, 8'h10, 1'b1);
      push(1, 8'h11, 1'b1);
      push(2, 8'h12, 1'b1);
      push(3, 8'h13, 1'b1);
      push(0, 8'h14, 1'b1);
      run_queues(5, ok);
      @(negedge clk);
      #1;
      vectors++;
      if (!ok || launch_d.size() != 5) begin
         $display("FAIL contention_count: got %0d accepts %0d launches, expected 5 and 5",
                  acc_rdy.size(), launch_d.size());
         miscompares++;
         return;
      end
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if (acc_rdy[k] !== exp_rdy[k] || launch_d[k] !== exp_d[k]) begin
            $display("FAIL contention_grant%0d: got ready=%b data=%h, expected ready=%b data=%h",
                     k, acc_rdy[k], launch_d[k], exp_rdy[k], exp_d[k]);
            miscompares++;
         end
         if (k > 0) begin
            vectors++;
            if (launch_t[k] - launch_t[k-1] !== 42) begin
               $display("FAIL contention_spacing%0d: got %0d, expected 42",
                        k, launch_t[k] - launch_t[k-1]);
               miscompares++;
            end
         end
         $display("contention: launch %0d data %h at cycle %0d", k, launch_d[k], launch_t[k]);
      end
   endtask

   task automatic test_lock();
      bit ok;
      logic [3:0] exp_rdy [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0001};
      logic [7:0] exp_d   [5] = '{8'h11, 8'h22, 8'h33, 8'hE3, 8'hE0};
      launch_d.delete();
      launch_t.delete();
      push(0, 8'hE0, 1'b1);
      push(1, 8'h11, 1'b0);
      push(1, 8'h22, 1'b0);
      push(1, 8'h33, 1'b1);
      push(3, 8'hE3, 1'b1);
      run_queues(5, ok);
      @(negedge clk);
      #1;
      vectors++;
      if (!ok || launch_d.size() != 5) begin
         $display("FAIL lock_count: got %0d accepts %0d launches, expected 5 and 5",
                  acc_rdy.size(), launch_d.size());
         miscompares++;
         return;
      end
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if (acc_rdy[k] !== exp_rdy[k] || launch_d[k] !== exp_d[k]) begin
            $display("FAIL lock_grant%0d: got ready=%b data=%h, expected ready=%b data=%h",
                     k, acc_rdy[k], launch_d[k], exp_rdy[k], exp_d[k]);
            miscompares++;
         end
         $display("lock: launch %0d data %h at cycle %0d", k, launch_d[k], launch_t[k]);
      end
   endtask

   task automatic test_wrap();
      bit ok;
      launch_d.delete();
      launch_t.delete();
      push(2, 8'hA2, 1'b1);
      run_queues(1, ok);
      vectors++;
      if (!ok || acc_rdy[0] !== 4'b0100) begin
         $display("FAIL wrap_setup: got ok=%b ready=%b, expected ok=1 ready=0100",
                  ok, (ok ? acc_rdy[0] : 4'b0000));
         miscompares++;
         return;
      end
      push(0, 8'hB0, 1'b1);
      push(3, 8'hB3, 1'b1);
      run_queues(2, ok);
      @(negedge clk);
      #1;
      vectors++;
      if (!ok || acc_rdy[0] !== 4'b1000 || acc_rdy[1] !== 4'b0001) begin
         $display("FAIL wrap_order: got ok=%b first=%b second=%b, expected 1000 then 0001",
                  ok, (ok ? acc_rdy[0] : 4'b0000), (ok ? acc_rdy[1] : 4'b0000));
         miscompares++;
         return;
      end
      vectors++;
      if (launch_d.size() != 3 || launch_d[1] !== 8'hB3 || launch_d[2] !== 8'hB0) begin
         $display("FAIL wrap_data: got %0d launches, expected a2 b3 b0", launch_d.size());
         miscompares++;
      end
      $display("wrap: req3 at cycle %0d then req0 at cycle %0d", acc_t[0], acc_t[1]);
   endtask

   task automatic test_reset_mid_wait();
      bit ok;
      int t;
      do_reset();
      push(1, 8'hC1, 1'b0);
      run_queues(1, ok);
      vectors++;
      if (!ok) begin
         $display("FAIL rstwait_setup: timeout, got no ready, expected 0010");
         miscompares++;
         return;
      end
      t = acc_t[0];
      for (int w = 0; w < 100 && cyc < t + 21; w++) @(negedge clk);
      rst = 1'b1;
      req_valid[0]      = 1'b1;
      req_data[7:0]     = 8'hD0;
      req_last[0]       = 1'b1;
      #1;
      vectors++;
      if ({req_ready, pi_data, pi_data_flag, tx_busy, grant_id} !== 16'h0000) begin
         $display("FAIL rstwait_outputs: got %h, expected 0000",
                  {req_ready, pi_data, pi_data_flag, tx_busy, grant_id});
         miscompares++;
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++;
      if (req_ready !== 4'b0001) begin
         $display("FAIL rstwait_first_idle: got ready=%b, expected 0001", req_ready);
         miscompares++;
      end
      @(posedge clk);
      #1;
      req_valid = 4'b0000;
      @(negedge clk);
      #1;
      vectors++;
      if (pi_data_flag !== 1'b1 || pi_data !== 8'hD0 || grant_id !== 2'd0) begin
         $display("FAIL rstwait_launch: got flag=%b data=%h id=%0d, expected 1 d0 0",
                  pi_data_flag, pi_data, grant_id);
         miscompares++;
      end
      $display("reset mid-wait: reset at cycle %0d, req0 launched at cycle %0d", t + 21, cyc);
   endtask

   task automatic test_withdraw();
      bit ok;
      int t;
      int bad;
      do_reset();
      launch_d.delete();
      launch_t.delete();
      push(0, 8'h60, 1'b1);
      run_queues(1, ok);
      vectors++;
      if (!ok) begin
         $display("FAIL withdraw_setup: timeout, got no ready, expected 0001");
         miscompares++;
         return;
      end
      t = acc_t[0];
      for (int w = 0; w < 100 && cyc < t + 10; w++) @(negedge clk);
      #1;
      req_valid[1]   = 1'b1;
      req_data[15:8] = 8'h61;
      req_last[1]    = 1'b1;
      bad = 0;
      #1;
      if (req_ready !== 4'b0000) bad++;
      @(negedge clk);
      #1;
      req_valid[1] = 1'b0;
      for (int w = 0; w < 100 && cyc < t + 60; w++) begin
         @(negedge clk);
         #1;
         if (req_ready !== 4'b0000) bad++;
      end
      vectors++;
      if (bad !== 0) begin
         $display("FAIL withdraw_ready: got %0d cycles with ready set, expected 0", bad);
         miscompares++;
      end
      vectors++;
      if (launch_d.size() !== 1 || tx_busy !== 1'b0) begin
         $display("FAIL withdraw_launches: got %0d launches busy=%b, expected 1 and 0",
                  launch_d.size(), tx_busy);
         miscompares++;
      end
      $display("withdraw: req1 pulse at cycle %0d, %0d launch(es)", t + 10, launch_d.size());
   endtask

   initial begin
      clear_queues();
      test_reset();
      test_single();
      test_contention();
      test_lock();
      test_wrap();
      test_reset_mid_wait();
      test_withdraw();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
